link_act_array: RTL and testbench
=================================

// Module: link_act_array
// PURPOSE
//  NCH-channel LINK/ACT/FAULT LED indicator for multi-port boards (e.g. 4-lane
//  link status). Every channel has a retriggerable activity hold timer and a
//  latched fault indication. One free-running prescaler drives all channels,
//  so every LED that blinks does so in phase. Sits between link/traffic status
//  logic and board LED pins.
// PARAMETERS
//  NCH        4   number of channels
//  BlinkBits  26  shared prescaler width; slow blink = PRESC[BlinkBits-1], fast = PRESC[BlinkBits-3] (>=3)
//  HoldBits   27  per-channel activity hold counter width; hold = 2^HoldBits-1 cycles
//  DimBits    4   PWM counter width (used only with LINK_ACT_DIM_EN)
// PORTS
//  CLK        in   1         clock
//  RST        in   1         asynchronous, active-high reset
//  LINK       in   NCH       per-channel link up (level)
//  ACT        in   NCH       per-channel activity strobe (1+ cycles)
//  ERR        in   NCH       per-channel error strobe; sets the fault latch
//  ERR_CLR    in   NCH       per-channel fault latch clear
//  LAMP_TEST  in   1         force all LEDs on
//  DIM        in   DimBits   brightness (only with LINK_ACT_DIM_EN)
//  LED        out  NCH       registered LED drive, active high
// BEHAVIOUR
//  - Reset (async, while RST=1): PRESC=0, HOLD[i]=0, FAULT[i]=0, LINK_Q=0,
//    PWM=0, LED=0. Asserting RST mid-blink forces LED=0 immediately.
//  - Stage 1 (registered): LINK_Q<=LINK; PRESC<=PRESC+1 (wraps, no saturation).
//  - HOLD[i]:
//    - LINK[i]=0: HOLD<=0, and ACT is ignored.
//    - else if ACT[i]: HOLD<=all-ones (retrigger allowed while non-zero).
//    - else if HOLD!=0: HOLD<=HOLD-1.
//    - Never wraps below 0.
//  - FAULT[i]: set by ERR[i], cleared by ERR_CLR[i]. ERR wins if both are high
//    in the same cycle. Independent of LINK.
//  - Channel state is decoded from stage-1 registers, priority high to low:
//    FAULT (FAULT=1) > ACTV (HOLD!=0) > UP (LINK_Q=1) > DOWN.
//  - Stage 2 LED[i] (registered):
//    - LAMP_TEST=1: 1.
//    - FAULT: PRESC[BlinkBits-3].
//    - ACTV: ~PRESC[BlinkBits-1].
//    - UP: 1.
//    - DOWN: 0.
//  - Latency: an input change sampled at edge t is visible on LED after edge
//    t+1 (2 cycles), for all inputs.
//  - ACTV duration: exactly 2^HoldBits-1 cycles after the last ACT, then UP.
//  - Channels are fully independent. Only PRESC (and PWM) are shared.
// CONFIGURATION
//  - LINK_ACT_DIM_EN defined:
//    - Adds the DIM port and a free-running PWM counter (DimBits).
//    - LED<=raw & ((PWM<DIM) | (DIM==all-ones)); DIM=0 gives off,
//      DIM=all-ones gives 100%.
//    - LAMP_TEST bypasses dimming.
//  - Undefined: no DIM port, no PWM logic; LED = raw value above.
// TESTING  (NCH=2, BlinkBits=3, HoldBits=4, DimBits=2)
//  1. RST pulse during ACTV -> LED=2'b00 within the reset cycle; after release
//     with LINK=0 -> LED stays 00.
//  2. LINK=2'b01 -> LED=2'b01 two cycles later; LINK[0]->0 -> LED[0]=0 two
//     cycles later.
//  3. LINK[0]=1, one-cycle ACT[0] -> LED[0]=~PRESC[2] for 15 cycles, then steady
//     1; ACT with LINK=0 -> LED stays 0.
//  4. ACT[0] pulses 10 cycles apart -> ACTV lasts 15 cycles past the second
//     pulse (25 total); LINK drop mid-ACTV -> LED[0]=0 and HOLD=0.
//  5. ERR[1] pulse -> LED[1] toggles every cycle (PRESC[0]) until ERR_CLR[1];
//     ERR and ERR_CLR in the same cycle -> fault kept.
//  6. LAMP_TEST=1 with all DOWN -> LED=2'b11 two cycles later; with DIM_EN,
//     DIM=1 in UP -> LED high 1 of 4 cycles; DIM=3 -> always high.

Source files
------------

// File: rtl/link_act_array.sv
// Multi-channel LINK/ACT/FAULT LED driver with a shared blink prescaler.
// Optional PWM dimming is compiled in with LINK_ACT_DIM_EN.
module link_act_array #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned BlinkBits = 26,
  parameter int unsigned HoldBits  = 27,
  parameter int unsigned DimBits   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NCH-1:0]     i_link,
  input  logic [NCH-1:0]     i_act,
  input  logic [NCH-1:0]     i_err,
  input  logic [NCH-1:0]     i_err_clr,
  input  logic               i_lamp_test,
`ifdef LINK_ACT_DIM_EN
  input  logic [DimBits-1:0] i_dim,
`endif
  output logic [NCH-1:0]     o_led
);

  typedef enum logic [1:0] {
    ST_DOWN,
    ST_UP,
    ST_ACTV,
    ST_FAULT
  } chan_state_t;

  logic [BlinkBits-1:0] r_presc;
  logic [NCH-1:0]       r_link_q;
  logic [NCH-1:0]       r_fault;
  logic                 r_lamp_q;
  logic [HoldBits-1:0]  r_hold [NCH];

  chan_state_t          w_state [NCH];
  logic [NCH-1:0]       w_led_raw;
  logic [NCH-1:0]       w_led_nxt;

  // Stage 1: every input is registered here so all paths to the LED share one latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc  <= '0;
      r_link_q <= '0;
      r_fault  <= '0;
      r_lamp_q <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      r_presc  <= r_presc + 1'b1;
      r_link_q <= i_link;
      r_lamp_q <= i_lamp_test;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!i_link[i]) begin
          r_hold[i] <= '0;
        end else if (i_act[i]) begin
          r_hold[i] <= '1;
        end else if (r_hold[i] != '0) begin
          r_hold[i] <= r_hold[i] - 1'b1;
        end
        if (i_err[i]) begin
          r_fault[i] <= 1'b1;
        end else if (i_err_clr[i]) begin
          r_fault[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      w_state[i]   = ST_DOWN;
      w_led_raw[i] = 1'b0;
      if (r_fault[i]) begin
        w_state[i] = ST_FAULT;
      end else if (r_hold[i] != '0) begin
        w_state[i] = ST_ACTV;
      end else if (r_link_q[i]) begin
        w_state[i] = ST_UP;
      end
      case (w_state[i])
        ST_FAULT: w_led_raw[i] = r_presc[BlinkBits-3];
        ST_ACTV:  w_led_raw[i] = ~r_presc[BlinkBits-1];
        ST_UP:    w_led_raw[i] = 1'b1;
        default:  w_led_raw[i] = 1'b0;
      endcase
    end
  end

`ifdef LINK_ACT_DIM_EN
  logic [DimBits-1:0] r_pwm;
  logic [DimBits-1:0] r_dim_q;
  logic               w_dim_gate;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pwm   <= '0;
      r_dim_q <= '0;
    end else begin
      r_pwm   <= r_pwm + 1'b1;
      r_dim_q <= i_dim;
    end
  end

  // Full-scale DIM is forced fully on; otherwise the duty would top out one step short.
  always_comb begin
    w_dim_gate = (r_pwm < r_dim_q) | (&r_dim_q);
    w_led_nxt  = r_lamp_q ? '1 : (w_led_raw & {NCH{w_dim_gate}});
  end
`else
  always_comb begin
    w_led_nxt = r_lamp_q ? '1 : w_led_raw;
  end
`endif

  // Stage 2: registered LED drive.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_led <= '0;
    end else begin
      o_led <= w_led_nxt;
    end
  end

endmodule

// File: tb/tb_link_act_array.sv
// Randomized plus directed bench for link_act_array against a cycle-age reference model.
// Build with LINK_ACT_DIM_EN defined to also exercise the dimming path.
module tb_link_act_array;
  localparam int NCH      = 2;
  localparam int BB       = 3;
  localparam int HB       = 4;
  localparam int DB       = 2;
  localparam int HOLD_LEN = (1 << HB) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] link, act, err, err_clr;
  logic           lamp;
  logic [NCH-1:0] led;
`ifdef LINK_ACT_DIM_EN
  logic [DB-1:0]  dim;
`endif

  link_act_array #(
    .NCH(NCH),
    .BlinkBits(BB),
    .HoldBits(HB),
    .DimBits(DB)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_link(link),
    .i_act(act),
    .i_err(err),
    .i_err_clr(err_clr),
    .i_lamp_test(lamp),
`ifdef LINK_ACT_DIM_EN
    .i_dim(dim),
`endif
    .o_led(led)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [NCH-1:0] got, input logic [NCH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks edges since reset and the edge of the last valid ACT.
  int             m_edge;
  bit             m_link_q  [NCH];
  bit             m_fault   [NCH];
  bit             m_act_ok  [NCH];
  int             m_last_act[NCH];
  bit             m_lamp_q;
  int             m_dim_q;
  logic [NCH-1:0] m_led;

  task automatic model_reset();
    m_edge   = 0;
    m_lamp_q = 0;
    m_dim_q  = 0;
    m_led    = '0;
    for (int i = 0; i < NCH; i++) begin
      m_link_q[i]   = 0;
      m_fault[i]    = 0;
      m_act_ok[i]   = 0;
      m_last_act[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic [NCH-1:0] nxt;
    int  presc;
    bit  r;
    bit  gate;
    presc = m_edge % (1 << BB);
    gate  = 1;
`ifdef LINK_ACT_DIM_EN
    gate = ((m_edge % (1 << DB)) < m_dim_q) || (m_dim_q == (1 << DB) - 1);
`endif
    for (int i = 0; i < NCH; i++) begin
      if (m_fault[i])
        r = ((presc >> (BB - 3)) & 1) != 0;
      else if (m_act_ok[i] && (m_edge - m_last_act[i]) <= HOLD_LEN)
        r = ((presc >> (BB - 1)) & 1) == 0;
      else
        r = m_link_q[i];
      nxt[i] = m_lamp_q ? 1'b1 : (r & gate);
    end
    for (int i = 0; i < NCH; i++) begin
      if (!link[i]) m_act_ok[i] = 0;
      else if (act[i]) begin
        m_act_ok[i]   = 1;
        m_last_act[i] = m_edge;
      end
      if (err[i]) m_fault[i] = 1;
      else if (err_clr[i]) m_fault[i] = 0;
      m_link_q[i] = link[i];
    end
    m_lamp_q = lamp;
`ifdef LINK_ACT_DIM_EN
    m_dim_q = int'(dim);
`endif
    m_edge++;
    m_led = nxt;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(tag, led, m_led);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  task automatic async_reset(input string tag);
    #1 rst = 1'b1;
    #1 check(tag, led, '0);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; link = '0; act = '0; err = '0; err_clr = '0; lamp = 1'b0;
`ifdef LINK_ACT_DIM_EN
    dim = '1;
`endif
    model_reset();
    #2 check("reset_led", led, '0);
    repeat (2) @(negedge clk);
    check("reset_hold", led, '0);
    rst = 1'b0;

    // Link up / down latency
    link = 2'b01; ticks("link_up", 4);
    link = 2'b00; ticks("link_down", 4);

    // Single ACT pulse, then ACT ignored with link down
    link = 2'b01; ticks("pre_act", 3);
    act = 2'b01; tick("act1");
    act = 2'b00; ticks("actv1", 20);
    link = 2'b00; act = 2'b01; tick("act_nolink");
    act = 2'b00; ticks("act_nolink_after", 4);

    // Retrigger then link drop mid-ACTV
    link = 2'b01; ticks("pre_retrig", 2);
    act = 2'b01; tick("retrig_a");
    act = 2'b00; ticks("retrig_gap", 9);
    act = 2'b01; tick("retrig_b");
    act = 2'b00; ticks("retrig_tail", 20);
    act = 2'b01; tick("drop_act");
    act = 2'b00; ticks("drop_pre", 4);
    link = 2'b00; ticks("drop_link", 3);
    link = 2'b01; ticks("drop_relink", 4);

    // Fault latch, ERR beats ERR_CLR
    link = 2'b11; err = 2'b10; tick("err_set");
    err = 2'b00; ticks("fault_blink", 10);
    err = 2'b10; err_clr = 2'b10; tick("err_both");
    err = 2'b00; err_clr = 2'b00; ticks("fault_kept", 5);
    err_clr = 2'b10; tick("err_clr");
    err_clr = 2'b00; ticks("fault_gone", 5);

    // Lamp test over DOWN
    link = 2'b00; lamp = 1'b1; ticks("lamp", 4);
    lamp = 1'b0; ticks("lamp_off", 3);

`ifdef LINK_ACT_DIM_EN
    link = 2'b11;
    dim = 2'd1; ticks("dim1", 8);
    dim = 2'd3; ticks("dim3", 8);
    dim = 2'd0; ticks("dim0", 6);
    lamp = 1'b1; ticks("dim0_lamp", 4);
    lamp = 1'b0; dim = 2'd2; ticks("dim2", 8);
    dim = 2'd3;
`endif

    // Async reset during ACTV, then stay down
    link = 2'b01; act = 2'b01; tick("rst_act");
    act = 2'b00; ticks("rst_actv", 2);
    link = 2'b00;
    async_reset("rst_async");
    ticks("rst_after", 6);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        link[i]    = ($urandom % 8) != 0;
        act[i]     = ($urandom % 7) == 0;
        err[i]     = ($urandom % 60) == 0;
        err_clr[i] = ($urandom % 12) == 0;
      end
      lamp = ($urandom % 50) == 0;
`ifdef LINK_ACT_DIM_EN
      if (($urandom % 20) == 0) dim = DB'($urandom);
`endif
      if (($urandom % 400) == 0) async_reset("rand_rst");
      tick("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
